// File: rtl/pe_drain_pkg.sv
// ---------------------------------------------------------------------------
// pe_drain_pkg
// Shared types and sizing helpers for the PE group result drain path
// (pe_result_packer, drain_fifo, pe_result_packer_if).
//   pack_state_e   : packer state (LOW = no half beat held, HIGH = low lane held)
//   Def*           : default parameter values for the drain path
//   beat_width()   : packed output beat width, 2*DataWidth
//   entry_width()  : FIFO entry width {tile, last, keep[1:0], data}
// ---------------------------------------------------------------------------
package pe_drain_pkg;

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } pack_state_e;

   localparam int unsigned DefDataWidth      = 32;
   localparam int unsigned DefBufferSize     = 4;
   localparam int unsigned DefBufferWidth    = 2;
   localparam int unsigned DefTileLength     = 4;
   localparam int unsigned DefTileCountWidth = 3;

   function automatic int unsigned beat_width(input int unsigned data_width);
      return 2 * data_width;
   endfunction

   function automatic int unsigned entry_width(input int unsigned tile_count_width,
                                               input int unsigned data_width);
      return tile_count_width + 1 + 2 + beat_width(data_width);
   endfunction

endpackage

// File: rtl/pe_result_packer_if.sv
// ---------------------------------------------------------------------------
// pe_result_packer_if
// Handshake bundle of the result packer.
//   Result stream in : DataInValid, DataInRdy, DataIn[DataWidth]
//   Beat stream out  : DataOutValid, DataOutRdy, DataOut[2*DataWidth],
//                      DataOutKeep[2], DataOutLast, DataOutTile[TileCountWidth]
//   Status           : Busy
// Modports:
//   slave  : the packer (consumes results, produces beats)
//   master : the environment (PE group + memory writer side)
// ---------------------------------------------------------------------------
interface pe_result_packer_if
   import pe_drain_pkg::*;
#(
   parameter int unsigned DataWidth      = DefDataWidth,
   parameter int unsigned TileCountWidth = DefTileCountWidth
);

   logic                        DataInValid;
   logic                        DataInRdy;
   logic [DataWidth-1:0]        DataIn;
   logic                        DataOutValid;
   logic                        DataOutRdy;
   logic [2*DataWidth-1:0]      DataOut;
   logic [1:0]                  DataOutKeep;
   logic                        DataOutLast;
   logic [TileCountWidth-1:0]   DataOutTile;
   logic                        Busy;

   modport slave (
      input  DataInValid, DataIn, DataOutRdy,
      output DataInRdy, DataOutValid, DataOut, DataOutKeep, DataOutLast,
             DataOutTile, Busy
   );

   modport master (
      output DataInValid, DataIn, DataOutRdy,
      input  DataInRdy, DataOutValid, DataOut, DataOutKeep, DataOutLast,
             DataOutTile, Busy
   );

endinterface

// File: rtl/drain_fifo.sv
// ---------------------------------------------------------------------------
// drain_fifo
// Synchronous FIFO with asynchronous active-low clear. The head entry is
// presented combinationally on head_o. Push on full and pop on empty are
// ignored.
//   clk          : clock, rising edge
//   aclr         : asynchronous clear, active low
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to write
//   pop_i        : drop the head entry
//   head_o       : head entry
//   full_o       : count_o == BufferSize
//   empty_o      : count_o == 0
//   count_o      : number of stored entries
// ---------------------------------------------------------------------------
module drain_fifo #(
   parameter int unsigned Width       = 8,
   parameter int unsigned BufferSize  = 4,
   parameter int unsigned BufferWidth = 2
) (
   input  logic                   clk,
   input  logic                   aclr,
   input  logic                   push_i,
   input  logic [Width-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [Width-1:0]       head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [BufferWidth:0]   count_o
);

   localparam logic [BufferWidth:0]   Depth   = (BufferWidth + 1)'(BufferSize);
   localparam logic [BufferWidth-1:0] LastPtr = BufferWidth'(BufferSize - 1);

   logic [Width-1:0]       mem_q [BufferSize];
   logic [BufferWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [BufferWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [BufferWidth:0]   count_q, count_d;
   logic                   do_push, do_pop;

   assign full_o  = (count_q == Depth);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Explicit wrap keeps non-power-of-two depths correct.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared too so the head (and thus the packer outputs) read
   // zero straight out of reset.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         for (int unsigned i = 0; i < BufferSize; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/pe_result_packer.sv
// ---------------------------------------------------------------------------
// pe_result_packer
// Packs the PE group's serialized result words into double-width beats,
// tagging each tile's final beat with last/keep/tile index, and buffers
// beats in a small FIFO so the ACC drain is decoupled from the writer.
//   clk   : clock, rising edge
//   aclr  : asynchronous reset, active low
//   bus   : pe_result_packer_if.slave
//           DataInValid/DataInRdy/DataIn      result stream in
//           DataOutValid/DataOutRdy/DataOut   packed beat out (first result
//                                             in the low lane)
//           DataOutKeep/DataOutLast/DataOutTile beat tags
//           Busy                              half beat held or FIFO non-empty
// Build option:
//   OUTPUT_RELU_EN : when defined, accepted words with MSB set are clamped
//                    to zero before packing.
// ---------------------------------------------------------------------------
module pe_result_packer
   import pe_drain_pkg::*;
#(
   parameter int unsigned DataWidth      = DefDataWidth,
   parameter int unsigned BufferSize     = DefBufferSize,
   parameter int unsigned BufferWidth    = DefBufferWidth,
   parameter int unsigned TileLength     = DefTileLength,
   parameter int unsigned TileCountWidth = DefTileCountWidth
) (
   input  logic                 clk,
   input  logic                 aclr,
   pe_result_packer_if.slave    bus
);

   localparam int unsigned BeatWidth  = beat_width(DataWidth);
   localparam int unsigned EntryWidth = entry_width(TileCountWidth, DataWidth);
   localparam int unsigned ElemWidth  = (TileLength > 1) ? $clog2(TileLength) : 1;
   localparam logic [ElemWidth-1:0] LastElem = ElemWidth'(TileLength - 1);

   pack_state_e               state_q;
   logic [DataWidth-1:0]      low_q;
   logic [ElemWidth-1:0]      elem_cnt_q;
   logic [TileCountWidth-1:0] tile_cnt_q;

   logic                      accept;
   logic                      last_elem;
   logic [DataWidth-1:0]      word;
   logic                      push;
   logic [1:0]                push_keep;
   logic [BeatWidth-1:0]      push_data;
   logic [EntryWidth-1:0]     push_entry;
   logic [EntryWidth-1:0]     head_entry;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [BufferWidth:0]      fifo_count;
   logic                      pop;

   // Ready ignores a same-cycle pop; this keeps the ready path registered-only.
   assign bus.DataInRdy    = aclr & ~fifo_full;
   assign accept           = bus.DataInValid & bus.DataInRdy;
   assign bus.DataOutValid = ~fifo_empty;
   assign pop              = bus.DataOutValid & bus.DataOutRdy;
   assign bus.Busy         = (state_q == HIGH) | (fifo_count != '0);

   assign {bus.DataOutTile, bus.DataOutLast, bus.DataOutKeep, bus.DataOut} = head_entry;

`ifdef OUTPUT_RELU_EN
   // Sign bit set covers negative integers and negative floats (incl. -0.0).
   assign word = bus.DataIn[DataWidth-1] ? '0 : bus.DataIn;
`else
   assign word = bus.DataIn;
`endif

   assign last_elem = (elem_cnt_q == LastElem);

   // A beat leaves the packer either when the high lane arrives or when the
   // tile ends on the low lane (odd tile tail, high lane zeroed).
   always_comb begin
      push      = accept & ((state_q == HIGH) | last_elem);
      push_keep = 2'b01;
      push_data = {{DataWidth{1'b0}}, word};
      if (state_q == HIGH) begin
         push_keep = 2'b11;
         push_data = {word, low_q};
      end
      push_entry = {tile_cnt_q, last_elem, push_keep, push_data};
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q    <= LOW;
         low_q      <= '0;
         elem_cnt_q <= '0;
         tile_cnt_q <= '0;
      end else if (accept) begin
         elem_cnt_q <= last_elem ? '0 : elem_cnt_q + 1'b1;
         // Every tile-final word pushes a last beat, so it alone advances
         // the tile index.
         if (last_elem) begin
            tile_cnt_q <= tile_cnt_q + 1'b1;
         end
         case (state_q)
            LOW: begin
               if (!last_elem) begin
                  low_q   <= word;
                  state_q <= HIGH;
               end
            end
            HIGH: begin
               state_q <= LOW;
            end
            default: begin
               state_q <= LOW;
            end
         endcase
      end
   end

   drain_fifo #(
      .Width       (EntryWidth),
      .BufferSize  (BufferSize),
      .BufferWidth (BufferWidth)
   ) u_fifo (
      .clk         (clk),
      .aclr        (aclr),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_pe_result_packer.sv
// ---------------------------------------------------------------------------
// tb_pe_result_packer
// Two packers (TileLength 4 and 3) sharing clock and reset. A reference model
// built from tile position arithmetic predicts every beat, ready, valid and
// busy value each cycle; directed checks cover reset values, clamping, full
// behaviour and reset mid-tile. Build option OUTPUT_RELU_EN is honoured.
// ---------------------------------------------------------------------------
module tb_pe_result_packer;

   localparam int unsigned BUF = 4;

   typedef struct packed {
      logic [2:0]  tile;
      logic        last;
      logic [1:0]  keep;
      logic [63:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        aclr;
   logic [1:0]  in_valid;
   logic [1:0]  out_rdy;
   logic [31:0] in_data [2];
   logic [1:0]  rdy_w;
   logic        rand_rdy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // reference model state, index 0 = TileLength 4, index 1 = TileLength 3
   beat_t       mq [2][64];
   int unsigned mh [2];
   int unsigned mt [2];
   int unsigned nw [2];
   logic        hv [2];
   logic [31:0] hw [2];

   always #5 clk = ~clk;

   pe_result_packer_if #(.DataWidth(32), .TileCountWidth(3)) bus4 ();
   pe_result_packer_if #(.DataWidth(32), .TileCountWidth(3)) bus3 ();

   assign bus4.DataInValid = in_valid[0];
   assign bus4.DataIn      = in_data[0];
   assign bus4.DataOutRdy  = out_rdy[0];
   assign bus3.DataInValid = in_valid[1];
   assign bus3.DataIn      = in_data[1];
   assign bus3.DataOutRdy  = out_rdy[1];
   assign rdy_w            = {bus3.DataInRdy, bus4.DataInRdy};

   pe_result_packer #(
      .DataWidth(32), .BufferSize(BUF), .BufferWidth(2),
      .TileLength(4), .TileCountWidth(3)
   ) dut4 (
      .clk(clk), .aclr(aclr), .bus(bus4)
   );

   pe_result_packer #(
      .DataWidth(32), .BufferSize(BUF), .BufferWidth(2),
      .TileLength(3), .TileCountWidth(3)
   ) dut3 (
      .clk(clk), .aclr(aclr), .bus(bus3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef OUTPUT_RELU_EN
      return w[31] ? 32'h0 : w;
`else
      return w;
`endif
   endfunction

   // Called at the negedge: checks this cycle's outputs, then advances the
   // model by the handshakes that complete at the coming posedge.
   task automatic mon(input int k, input int unsigned tl, input logic rst_n,
                      input logic ir, input logic iv, input logic [31:0] id,
                      input logic ov, input logic orr, input logic [63:0] od,
                      input logic [1:0] ok, input logic ol, input logic [2:0] ot,
                      input logic bz);
      int unsigned sz;
      int unsigned pos;
      logic [2:0]  tile;
      logic        m_rdy;
      logic [31:0] w;
      beat_t       b;
      if (!rst_n) begin
         mh[k] = 0; mt[k] = 0; nw[k] = 0; hv[k] = 1'b0;
      end
      sz    = mt[k] - mh[k];
      m_rdy = rst_n && (sz < BUF);
      check($sformatf("u%0d.in_rdy", k), 64'(ir), 64'(m_rdy));
      check($sformatf("u%0d.out_valid", k), 64'(ov), 64'(sz != 0));
      check($sformatf("u%0d.busy", k), 64'(bz), 64'(hv[k] || sz != 0));
      if (sz != 0) begin
         b = mq[k][mh[k] % 64];
         check($sformatf("u%0d.data", k), od, b.data);
         check($sformatf("u%0d.keep", k), 64'(ok), 64'(b.keep));
         check($sformatf("u%0d.last", k), 64'(ol), 64'(b.last));
         check($sformatf("u%0d.tile", k), 64'(ot), 64'(b.tile));
         if (orr) mh[k]++;
      end
      if (iv && m_rdy) begin
         w    = relu(id);
         pos  = nw[k] % tl;
         tile = 3'((nw[k] / tl) % 8);
         if (pos % 2 == 1) begin
            mq[k][mt[k] % 64] = '{tile: tile, last: (pos == tl - 1), keep: 2'b11, data: {w, hw[k]}};
            mt[k]++;
            hv[k] = 1'b0;
         end else if (pos == tl - 1) begin
            mq[k][mt[k] % 64] = '{tile: tile, last: 1'b1, keep: 2'b01, data: {32'h0, w}};
            mt[k]++;
         end else begin
            hw[k] = w;
            hv[k] = 1'b1;
         end
         nw[k]++;
      end
   endtask

   always @(negedge clk) begin
      mon(0, 4, aclr, bus4.DataInRdy, bus4.DataInValid, bus4.DataIn, bus4.DataOutValid,
          bus4.DataOutRdy, bus4.DataOut, bus4.DataOutKeep, bus4.DataOutLast,
          bus4.DataOutTile, bus4.Busy);
      mon(1, 3, aclr, bus3.DataInRdy, bus3.DataInValid, bus3.DataIn, bus3.DataOutValid,
          bus3.DataOutRdy, bus3.DataOut, bus3.DataOutKeep, bus3.DataOutLast,
          bus3.DataOutTile, bus3.Busy);
   end

   always @(posedge clk) begin
      #2;
      if (rand_rdy) out_rdy = 2'($urandom);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [31:0] w);
      int unsigned t = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = w;
      @(negedge clk);
      while (!rdy_w[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rdy_w[k]) check($sformatf("u%0d.send_accept", k), 64'(rdy_w[k]), 64'd1);
      step();
      in_valid[k] = 1'b0;
   endtask

   task automatic drain();
      int unsigned t = 0;
      out_rdy = 2'b11;
      @(negedge clk);
      while ((bus4.DataOutValid || bus3.DataOutValid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'({bus3.DataOutValid, bus4.DataOutValid}), 64'd0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      aclr       = 1'b0;
      in_valid   = '0;
      out_rdy    = '0;
      in_data[0] = '0;
      in_data[1] = '0;
      rand_rdy   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mh[i] = 0; mt[i] = 0; nw[i] = 0; hv[i] = 1'b0; hw[i] = '0;
      end

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.data", bus4.DataOut, 64'd0);
      check("rst.keep", 64'(bus4.DataOutKeep), 64'd0);
      check("rst.last", 64'(bus4.DataOutLast), 64'd0);
      check("rst.tile", 64'(bus4.DataOutTile), 64'd0);
      check("rst.data3", bus3.DataOut, 64'd0);
      @(posedge clk);
      #1 aclr = 1'b1;

      // TileLength 4: 1,2,3,4 back to back
      out_rdy = 2'b11;
      send(0, 32'd1); send(0, 32'd2); send(0, 32'd3); send(0, 32'd4);
      // TileLength 3: two tiles, odd tails
      send(1, 32'd5); send(1, 32'd6); send(1, 32'd7);
      send(1, 32'd8); send(1, 32'd9); send(1, 32'd10);
      drain();

      // fill: 8 results, writer stalled
      out_rdy = 2'b00;
      for (int i = 0; i < 8; i++) send(0, 32'(100 + i));
      in_valid[0] = 1'b1;
      in_data[0]  = 32'd99;
      repeat (4) step();
      @(negedge clk);
      check("full.rdy", 64'(bus4.DataInRdy), 64'd0);
      step();
      out_rdy[0] = 1'b1;
      step();
      out_rdy[0] = 1'b0;
      @(negedge clk);
      check("full.rdy_after_pop", 64'(bus4.DataInRdy), 64'd1);
      step();
      in_valid[0] = 1'b0;
      drain();
      send(0, 32'd200); send(0, 32'd201); send(0, 32'd202);
      drain();

      // clamp
      out_rdy = 2'b00;
      send(0, 32'hBF80_0000);
      send(0, 32'h3F80_0000);
      @(negedge clk);
`ifdef OUTPUT_RELU_EN
      check("relu.beat", bus4.DataOut, 64'h3F80_0000_0000_0000);
`else
      check("relu.beat", bus4.DataOut, 64'h3F80_0000_BF80_0000);
`endif
      step();
      out_rdy = 2'b11;
      send(0, 32'h8000_0000); send(0, 32'h7FFF_FFFF);
      drain();

      // random: tile index wrap on both widths
      rand_rdy = 1'b1;
      for (int t = 0; t < 36; t++) begin
         repeat ($urandom_range(0, 2)) step();
         send(0, $urandom);
      end
      for (int t = 0; t < 30; t++) begin
         repeat ($urandom_range(0, 2)) step();
         send(1, $urandom);
      end
      rand_rdy = 1'b0;
      step();
      drain();

      // reset mid-tile
      send(0, 32'h1234_5678);
      @(negedge clk);
      check("midrst.busy_before", 64'(bus4.Busy), 64'd1);
      step();
      aclr = 1'b0;
      @(negedge clk);
      check("midrst.busy", 64'(bus4.Busy), 64'd0);
      check("midrst.valid", 64'(bus4.DataOutValid), 64'd0);
      step();
      aclr = 1'b1;
      out_rdy = 2'b00;
      send(0, 32'hAAAA_0001); send(0, 32'hAAAA_0002);
      @(negedge clk);
      check("midrst.tile", 64'(bus4.DataOutTile), 64'd0);
      check("midrst.keep", 64'(bus4.DataOutKeep), 64'd3);
      check("midrst.data", bus4.DataOut, 64'hAAAA_0002_AAAA_0001);
      step();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
